sdr_ram_resp: RTL and testbench
===============================

Name: sdr_ram_resp

Overview:
Cycle-accurate SDRAM device responder: the memory end of the SDRAM command bus. It decodes cs_n/ras_n/cas_n/we_n/ba/addr issued by the controller core and keeps per-bank open-row state and a programmed mode register. It stores write bursts in a small internal array and returns read bursts after the programmed CAS latency. It serves as the memory stand-in for controller-core simulation and FPGA loopback, and flags illegal command sequences on proto_err.

Parameters:
SDR_DW, 16, data width
SDR_BW, 2, byte lanes (SDR_DW/8)
ROW_AW, 2, modelled row address bits (addr[ROW_AW-1:0])
COL_AW, 6, modelled column address bits (addr[COL_AW-1:0]); array = 4 x 2^ROW_AW x 2^COL_AW words

Ports:
sdram_clk  in  1  clock
sdram_rst  in  1  asynchronous active-high reset
sdr_cke  in  1  clock enable; 0 = suspend
sdr_cs_n  in  1  chip select
sdr_ras_n  in  1  RAS
sdr_cas_n  in  1  CAS
sdr_we_n  in  1  write enable
sdr_ba  in  2  bank address
sdr_addr  in  13  row/column address; bit 10 = auto-precharge / all-banks
sdr_dqm  in  SDR_BW  byte mask
sdr_din  in  SDR_DW  write data from controller
sdr_dout  out  SDR_DW  read data
sdr_doe  out  SDR_BW  per-byte read output enable
proto_err  out  1  one-cycle pulse on an illegal command
refresh_cnt  out  16  count of AUTO REFRESH commands, wraps

Behaviour:
- Reset (async) values:
  - outputs: sdr_dout=0, sdr_doe=0, proto_err=0, refresh_cnt=0.
  - state: all banks closed, mode BL=1, CL=2, burst write mode, no burst active, read pipeline empty. Array contents are not reset.
- Reset mid-burst aborts the burst and clears the pipeline immediately.
- Clock enable:
  - sdr_cke=0: no command is decoded; burst counters, pipeline and outputs hold.
  - Decoding resumes on the first edge with cke=1.
- Command decode: {cs_n,ras_n,cas_n,we_n} sampled on the rising edge.
  - cs_n=1 or 0111: NOP.
  - 0000: LOAD MODE.
  - 0001: AUTO REFRESH.
  - 0010: PRECHARGE.
  - 0011: ACTIVE.
  - 0100: WRITE.
  - 0101: READ.
  - 0110: BURST TERMINATE.
- LOAD MODE:
  - Any bank open or burst active -> proto_err, ignored.
  - addr[2:0] sets BL: 000=1, 001=2, 010=4, 011=8, 111=full page (2^COL_AW).
  - addr[6:4] sets CL: 2 or 3.
  - addr[9]=1 selects single-location writes.
  - Reserved BL/CL codes -> proto_err, mode unchanged.
- ACTIVE: bank closed -> open, latch row. Bank already open -> proto_err, ignored.
- READ/WRITE:
  - Target bank closed -> proto_err, ignored.
  - Otherwise start a burst: start column = addr[COL_AW-1:0], AP = addr[10].
  - A new READ/WRITE replaces any active burst immediately (interrupt).
  - Column sequence is sequential and wraps within the BL-aligned block: col = {start[COL_AW-1:k], (start[k-1:0]+n) mod BL}, k=log2 BL. Full page wraps mod 2^COL_AW.
- Write burst:
  - Beat n is written on the nth cycle, n=0 on the command edge, using sdr_din.
  - Bytes with sdr_dqm[b]=1 on that edge are not written (DQM write latency 0).
  - Single-location write mode forces burst length 1 for writes.
- Read burst:
  - Each beat's word is fetched on its edge and pushed into a CL-stage delay line.
  - Beat n appears on sdr_dout with sdr_doe=~dqm_d2 exactly CL cycles after its issue edge, so first data is CL cycles after READ. dqm_d2 is sdr_dqm sampled 2 edges before output (DQM read latency 2).
  - sdr_doe=0 and sdr_dout holds its last value when no beat is due.
- BURST TERMINATE: stops issuing beats. Beats already in the delay line still emerge. No active burst -> ignored, no error.
- PRECHARGE:
  - addr[10]=1 closes all banks; otherwise closes sdr_ba.
  - Precharging the bank of the active burst truncates it; in-flight read beats still emerge.
  - Precharging a closed bank is legal.
- Auto-precharge: bank closes on the edge after the final beat issues. Any READ/WRITE/BST to that bank before then -> proto_err.
- AUTO REFRESH:
  - Any bank open -> proto_err, no count.
  - Otherwise refresh_cnt increments.
- WRITE issued while the read delay line still holds beats -> proto_err. The write still executes and the old beats are still driven.
- proto_err is registered: high on the edge after the offending command, for exactly one cycle.

Test Plan:
1. Reset; LOAD MODE addr=0x022 (BL4, CL2); ACTIVE ba=1 row=2; WRITE ba=1 col=4, din=A0,A1,A2,A3 -> then READ ba=1 col=4: sdr_doe=2'b11 at cycles 2-5 after READ, dout=A0..A3, proto_err stays 0.
2. BL4 CL3, READ col=6 -> data order col6,7,4,5; first beat at cycle 3.
3. WRITE col=0 BL2 with dqm=2'b10 on beat 0 -> later read returns old upper byte, new lower byte; read with dqm=2'b01 at READ edge -> beat 2 cycles later has sdr_doe=2'b10.
4. READ to closed bank, ACTIVE to open bank, AUTO REFRESH with bank open -> proto_err pulses once each; refresh_cnt unchanged. After PRECHARGE addr[10]=1, AUTO REFRESH -> refresh_cnt=1.
5. READ BL8 with AP=1, BURST TERMINATE at beat 3 -> exactly 4 beats (CL pipeline drains); then ACTIVE same bank -> proto_err (AP not reached, bank open).
6. sdram_rst asserted during BL8 read, sdr_cke=0 for 3 cycles mid-burst -> the cke stall extends the burst by 3 cycles with outputs held; reset forces sdr_doe=0 asynchronously, and a subsequent READ without ACTIVE -> proto_err.

Source files
------------

// File: rtl/sdr_ram_resp.sv
// SDRAM device-side responder: decodes the command bus, tracks banks
// and mode, stores write bursts and returns read bursts after CL.
module sdr_ram_resp #(
  parameter int SDR_DW = 16,
  parameter int SDR_BW = 2,
  parameter int ROW_AW = 2,
  parameter int COL_AW = 6
) (
  input  logic              sdram_clk,
  input  logic              sdram_rst,
  input  logic              sdr_cke,
  input  logic              sdr_cs_n,
  input  logic              sdr_ras_n,
  input  logic              sdr_cas_n,
  input  logic              sdr_we_n,
  input  logic [1:0]        sdr_ba,
  input  logic [12:0]       sdr_addr,
  input  logic [SDR_BW-1:0] sdr_dqm,
  input  logic [SDR_DW-1:0] sdr_din,
  output logic [SDR_DW-1:0] sdr_dout,
  output logic [SDR_BW-1:0] sdr_doe,
  output logic              proto_err,
  output logic [15:0]       refresh_cnt
);
  localparam int AW = 2 + ROW_AW + COL_AW;
  localparam int CW = COL_AW + 1;

  logic [SDR_DW-1:0] r_mem [0:2**AW-1];
  logic [3:0]        r_open;
  logic [ROW_AW-1:0] r_row [4];
  logic [CW-1:0]     r_bl;
  logic [1:0]        r_cl;
  logic              r_wsingle;
  logic              r_bact;
  logic              r_brd;
  logic              r_bap;
  logic [1:0]        r_bbank;
  logic [ROW_AW-1:0] r_brow;
  logic [COL_AW-1:0] r_bcol0;
  logic [CW-1:0]     r_bn;
  logic [CW-1:0]     r_blen;
  logic              r_append;
  logic [1:0]        r_apbank;
  logic [2:0]        r_pv;
  logic [SDR_DW-1:0] r_pd [3];
  logic [SDR_BW-1:0] r_dqm1;
  logic [SDR_BW-1:0] r_dqm2;

  logic [3:0] w_cmd;
  logic w_lmr, w_ref, w_pre, w_act;
  logic w_wr, w_rd, w_bst;
  logic w_bl_ok, w_cl_ok, w_lmr_ok;
  logic [CW-1:0] w_bl_new;
  logic w_apb_cmd, w_apb_any;
  logic w_rw_ok, w_bst_go, w_pre_hit;
  logic w_issue, w_is_rd, w_iap, w_last;
  logic [1:0] w_ib;
  logic [ROW_AW-1:0] w_irow;
  logic [COL_AW-1:0] w_start, w_mask, w_icol;
  logic [CW-1:0] w_in, w_ilen, w_lenm1;
  logic [AW-1:0] w_addr;
  logic [SDR_DW-1:0] w_rdata;
  logic w_err;
  logic w_unused;

  assign w_cmd = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
  assign w_lmr = sdr_cke & (w_cmd == 4'b0000);
  assign w_ref = sdr_cke & (w_cmd == 4'b0001);
  assign w_pre = sdr_cke & (w_cmd == 4'b0010);
  assign w_act = sdr_cke & (w_cmd == 4'b0011);
  assign w_wr  = sdr_cke & (w_cmd == 4'b0100);
  assign w_rd  = sdr_cke & (w_cmd == 4'b0101);
  assign w_bst = sdr_cke & (w_cmd == 4'b0110);

  // Decode the burst-length field of a LOAD MODE
  always_comb begin
    w_bl_ok  = 1'b1;
    w_bl_new = CW'(1);
    unique case (sdr_addr[2:0])
      3'b000:  w_bl_new = CW'(1);
      3'b001:  w_bl_new = CW'(2);
      3'b010:  w_bl_new = CW'(4);
      3'b011:  w_bl_new = CW'(8);
      3'b111:  w_bl_new = CW'(2**COL_AW);
      default: w_bl_ok  = 1'b0;
    endcase
  end

  assign w_cl_ok  = (sdr_addr[6:4] == 3'd2) |
                    (sdr_addr[6:4] == 3'd3);
  assign w_lmr_ok = w_lmr & (r_open == 4'd0) & ~r_bact &
                    w_bl_ok & w_cl_ok;

  // Banks with an auto-precharge still pending
  assign w_apb_cmd = (r_bact & r_bap & (r_bbank == sdr_ba)) |
                     (r_append & (r_apbank == sdr_ba));
  assign w_apb_any = (r_bact & r_bap) | r_append;

  assign w_rw_ok   = (w_rd | w_wr) & r_open[sdr_ba] & ~w_apb_cmd;
  assign w_bst_go  = w_bst & r_bact;
  assign w_pre_hit = w_pre & r_bact &
                     (sdr_addr[10] | (sdr_ba == r_bbank));

  // Beat issued on this edge: new burst or continuation
  assign w_issue = w_rw_ok |
                   (sdr_cke & r_bact & ~w_bst_go & ~w_pre_hit);
  assign w_is_rd = w_rw_ok ? w_rd : r_brd;
  assign w_iap   = w_rw_ok ? sdr_addr[10] : r_bap;
  assign w_ib    = w_rw_ok ? sdr_ba : r_bbank;
  assign w_irow  = w_rw_ok ? r_row[sdr_ba] : r_brow;
  assign w_start = w_rw_ok ? sdr_addr[COL_AW-1:0] : r_bcol0;
  assign w_in    = w_rw_ok ? CW'(0) : r_bn;
  assign w_ilen  = !w_rw_ok ? r_blen :
                   (w_wr & r_wsingle) ? CW'(1) : r_bl;
  assign w_lenm1 = w_ilen - CW'(1);
  assign w_mask  = w_lenm1[COL_AW-1:0];
  assign w_last  = (w_in == w_lenm1);
  assign w_icol  = (w_start & ~w_mask) |
                   ((w_start + w_in[COL_AW-1:0]) & w_mask);
  assign w_addr  = {w_ib, w_irow, w_icol};
  assign w_rdata = r_mem[w_addr];

  assign w_err = (w_lmr & ~w_lmr_ok) |
                 (w_ref & (|r_open)) |
                 (w_act & r_open[sdr_ba]) |
                 ((w_rd | w_wr) & ~w_rw_ok) |
                 (w_bst & w_apb_any) |
                 (w_wr & (|r_pv));

  assign w_unused = ^{sdr_addr[12:11], sdr_addr[8:7], sdr_addr[3]};

  // Byte-masked storage of write beats
  always_ff @(posedge sdram_clk) begin
    if (w_issue && !w_is_rd) begin
      for (int b = 0; b < SDR_BW; b++) begin
        if (!sdr_dqm[b])
          r_mem[w_addr][b*8 +: 8] <= sdr_din[b*8 +: 8];
      end
    end
  end

  // Bank, mode, burst and read-pipeline state
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      sdr_dout    <= '0;
      sdr_doe     <= '0;
      proto_err   <= 1'b0;
      refresh_cnt <= 16'd0;
      r_open      <= 4'd0;
      for (int i = 0; i < 4; i++) r_row[i] <= '0;
      r_bl        <= CW'(1);
      r_cl        <= 2'd2;
      r_wsingle   <= 1'b0;
      r_bact      <= 1'b0;
      r_brd       <= 1'b0;
      r_bap       <= 1'b0;
      r_bbank     <= 2'd0;
      r_brow      <= '0;
      r_bcol0     <= '0;
      r_bn        <= '0;
      r_blen      <= CW'(1);
      r_append    <= 1'b0;
      r_apbank    <= 2'd0;
      r_pv        <= 3'd0;
      for (int i = 0; i < 3; i++) r_pd[i] <= '0;
      r_dqm1      <= '0;
      r_dqm2      <= '0;
    end else begin
      proto_err <= w_err;
      if (sdr_cke) begin
        r_dqm1 <= sdr_dqm;
        r_dqm2 <= r_dqm1;
        r_pv    <= {1'b0, r_pv[2:1]};
        r_pd[0] <= r_pd[1];
        r_pd[1] <= r_pd[2];
        if (w_issue && w_is_rd) begin
          r_pv[r_cl - 2'd1] <= 1'b1;
          r_pd[r_cl - 2'd1] <= w_rdata;
        end
        if (r_pv[0]) begin
          sdr_dout <= r_pd[0];
          sdr_doe  <= ~r_dqm2;
        end else begin
          sdr_doe  <= '0;
        end
        if (w_lmr_ok) begin
          r_bl      <= w_bl_new;
          r_cl      <= sdr_addr[5:4];
          r_wsingle <= sdr_addr[9];
        end
        if (w_ref && r_open == 4'd0)
          refresh_cnt <= refresh_cnt + 16'd1;
        if (r_append) begin
          r_open[r_apbank] <= 1'b0;
          r_append         <= 1'b0;
        end
        if (w_act && !r_open[sdr_ba]) begin
          r_open[sdr_ba] <= 1'b1;
          r_row[sdr_ba]  <= sdr_addr[ROW_AW-1:0];
        end
        if (w_pre) begin
          if (sdr_addr[10]) r_open <= 4'd0;
          else r_open[sdr_ba] <= 1'b0;
        end
        if (w_issue && w_last && w_iap) begin
          r_append <= 1'b1;
          r_apbank <= w_ib;
        end
        if (w_rw_ok) begin
          r_brd   <= w_rd;
          r_bap   <= sdr_addr[10];
          r_bbank <= sdr_ba;
          r_brow  <= r_row[sdr_ba];
          r_bcol0 <= sdr_addr[COL_AW-1:0];
          r_blen  <= w_ilen;
          r_bn    <= CW'(1);
          r_bact  <= ~w_last;
        end else if (w_bst_go || w_pre_hit) begin
          r_bact <= 1'b0;
        end else if (w_issue) begin
          r_bn <= r_bn + CW'(1);
          if (w_last) r_bact <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sdr_ram_resp.sv
// Directed bench for sdr_ram_resp: burst order, CL, DQM, protocol
// errors, refresh counting, clock-enable stall and async reset.
module tb_sdr_ram_resp;
  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] LMR = 4'b0000;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] BST = 4'b0110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b1;
  logic        cs_n = 1'b0;
  logic        ras_n = 1'b1;
  logic        cas_n = 1'b1;
  logic        we_n = 1'b1;
  logic [1:0]  ba = 2'd0;
  logic [12:0] addr = 13'd0;
  logic [1:0]  dqm = 2'd0;
  logic [15:0] din = 16'd0;
  logic [15:0] dout;
  logic [1:0]  doe;
  logic        perr;
  logic [15:0] rcnt;

  int errors = 0;
  int checks = 0;

  sdr_ram_resp dut (
    .sdram_clk  (clk),
    .sdram_rst  (rst),
    .sdr_cke    (cke),
    .sdr_cs_n   (cs_n),
    .sdr_ras_n  (ras_n),
    .sdr_cas_n  (cas_n),
    .sdr_we_n   (we_n),
    .sdr_ba     (ba),
    .sdr_addr   (addr),
    .sdr_dqm    (dqm),
    .sdr_din    (din),
    .sdr_dout   (dout),
    .sdr_doe    (doe),
    .proto_err  (perr),
    .refresh_cnt(rcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [3:0] c, input logic [1:0] b = 2'd0,
                     input logic [12:0] a = 13'd0,
                     input logic [15:0] d = 16'd0,
                     input logic [1:0] m = 2'd0);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba = b;
    addr = a;
    din = d;
    dqm = m;
    @(negedge clk);
  endtask

  task automatic beat(input string tag, input logic [15:0] d,
                      input logic [1:0] e);
    chk({tag, "_doe"}, 32'(doe), 32'(e));
    chk({tag, "_dout"}, 32'(dout), 32'(d));
  endtask

  initial begin
    cmd(NOP);
    cmd(NOP);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_doe", 32'(doe), 32'h0);
    chk("rst_perr", 32'(perr), 32'h0);
    chk("rst_rcnt", 32'(rcnt), 32'h0);
    rst = 1'b0;
    cmd(NOP);

    // 1: BL4 CL2 write then read back
    cmd(LMR, 2'd0, 13'h022);
    chk("t1_lmr_perr", 32'(perr), 32'h0);
    cmd(ACT, 2'd1, 13'd2);
    cmd(WR, 2'd1, 13'd4, 16'hA000);
    cmd(NOP, 2'd0, 13'd0, 16'hA001);
    cmd(NOP, 2'd0, 13'd0, 16'hA002);
    cmd(NOP, 2'd0, 13'd0, 16'hA003);
    chk("t1_wr_perr", 32'(perr), 32'h0);
    cmd(RD, 2'd1, 13'd4);
    cmd(NOP);
    chk("t1_c1_doe", 32'(doe), 32'h0);
    cmd(NOP);
    beat("t1_b0", 16'hA000, 2'b11);
    cmd(NOP);
    beat("t1_b1", 16'hA001, 2'b11);
    cmd(NOP);
    beat("t1_b2", 16'hA002, 2'b11);
    cmd(NOP);
    beat("t1_b3", 16'hA003, 2'b11);
    chk("t1_perr", 32'(perr), 32'h0);
    cmd(NOP);
    beat("t1_end", 16'hA003, 2'b00);

    // 2: BL4 CL3, wrapped read from col 6
    cmd(PRE, 2'd0, 13'h400);
    cmd(LMR, 2'd0, 13'h032);
    cmd(ACT, 2'd1, 13'd2);
    chk("t2_perr", 32'(perr), 32'h0);
    cmd(RD, 2'd1, 13'd6);
    cmd(NOP);
    cmd(NOP);
    chk("t2_c2_doe", 32'(doe), 32'h0);
    cmd(NOP);
    beat("t2_b0", 16'hA002, 2'b11);
    cmd(NOP);
    beat("t2_b1", 16'hA003, 2'b11);
    cmd(NOP);
    beat("t2_b2", 16'hA000, 2'b11);
    cmd(NOP);
    beat("t2_b3", 16'hA001, 2'b11);
    cmd(NOP);
    chk("t2_end_doe", 32'(doe), 32'h0);

    // 3: BL2 CL2, write byte mask and read DQM latency
    cmd(PRE, 2'd0, 13'h400);
    cmd(LMR, 2'd0, 13'h021);
    cmd(ACT, 2'd0, 13'd1);
    cmd(WR, 2'd0, 13'd0, 16'h1111);
    cmd(NOP, 2'd0, 13'd0, 16'h2222);
    cmd(WR, 2'd0, 13'd0, 16'hABCD, 2'b10);
    cmd(NOP, 2'd0, 13'd0, 16'hEEEE);
    cmd(RD, 2'd0, 13'd0, 16'h0, 2'b01);
    cmd(NOP);
    cmd(NOP);
    beat("t3_b0", 16'h11CD, 2'b10);
    cmd(NOP);
    beat("t3_b1", 16'hEEEE, 2'b11);
    cmd(NOP);
    chk("t3_end_doe", 32'(doe), 32'h0);

    // 4: protocol errors and refresh counting
    cmd(RD, 2'd2, 13'd0);
    chk("t4_rd_closed", 32'(perr), 32'h1);
    cmd(NOP);
    chk("t4_pulse1", 32'(perr), 32'h0);
    cmd(ACT, 2'd0, 13'd1);
    chk("t4_act_open", 32'(perr), 32'h1);
    cmd(NOP);
    chk("t4_pulse2", 32'(perr), 32'h0);
    cmd(REF);
    chk("t4_ref_open", 32'(perr), 32'h1);
    chk("t4_rcnt0", 32'(rcnt), 32'h0);
    cmd(PRE, 2'd0, 13'h400);
    chk("t4_pre_perr", 32'(perr), 32'h0);
    cmd(REF);
    chk("t4_rcnt1", 32'(rcnt), 32'h1);
    chk("t4_ref_perr", 32'(perr), 32'h0);

    // 5: BL8 read with AP, terminated after 4 beats
    cmd(LMR, 2'd0, 13'h023);
    cmd(ACT, 2'd3, 13'd0);
    for (int i = 0; i < 8; i++)
      cmd(i == 0 ? WR : NOP, 2'd3, 13'd0, 16'h3000 + 16'(i));
    chk("t5_wr_perr", 32'(perr), 32'h0);
    cmd(RD, 2'd3, 13'h400);
    cmd(NOP);
    cmd(NOP);
    beat("t5_b0", 16'h3000, 2'b11);
    cmd(NOP);
    beat("t5_b1", 16'h3001, 2'b11);
    cmd(BST);
    beat("t5_b2", 16'h3002, 2'b11);
    cmd(NOP);
    beat("t5_b3", 16'h3003, 2'b11);
    cmd(NOP);
    beat("t5_b4", 16'h3003, 2'b00);
    cmd(ACT, 2'd3, 13'd0);
    chk("t5_act_perr", 32'(perr), 32'h1);
    chk("t5_b5_doe", 32'(doe), 32'h0);

    // 6: clock-enable stall and async reset mid-burst
    cmd(RD, 2'd3, 13'd0);
    cmd(NOP);
    cmd(NOP);
    beat("t6_b0", 16'h3000, 2'b11);
    cke = 1'b0;
    cmd(NOP);
    beat("t6_hold1", 16'h3000, 2'b11);
    cmd(NOP);
    cmd(NOP);
    beat("t6_hold3", 16'h3000, 2'b11);
    cke = 1'b1;
    cmd(NOP);
    beat("t6_b1", 16'h3001, 2'b11);
    cmd(NOP);
    beat("t6_b2", 16'h3002, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_doe", 32'(doe), 32'h0);
    chk("t6_rst_dout", 32'(dout), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cmd(RD, 2'd3, 13'd0);
    chk("t6_rd_perr", 32'(perr), 32'h1);
    cmd(NOP);
    cmd(NOP);
    cmd(NOP);
    chk("t6_post_doe", 32'(doe), 32'h0);
    chk("t6_rcnt", 32'(rcnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
